// File: rtl/step_ctrl_pkg.sv
// Shared encodings for the step controller and its helpers.
package step_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AUTO = 2'd1,
    ST_STEP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage : step_ctrl_pkg

// File: rtl/btn_debounce.sv
// Two-FF synchroniser plus hold-time debounce for a board pushbutton.
// Emits a one-cycle pulse when the accepted level goes 0->1.
module btn_debounce #(
  parameter int unsigned DEB_CNT = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic pulse
);

  localparam int unsigned CNT_W = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CNT - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      stable  <= 1'b0;
      cnt     <= '0;
      pulse   <= 1'b0;
    end else begin
      sync_p0 <= btn_in;
      sync_p1 <= sync_p0;
      pulse   <= 1'b0;
      if (sync_p1 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // New level has held long enough; a rising acceptance is the press
        stable <= sync_p1;
        cnt    <= '0;
        pulse  <= sync_p1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule : btn_debounce

// File: rtl/step_ctrl.sv
// Turns clk_10 rising edges (auto-run) or debounced presses (single-step)
// into one-cycle solver step enables, and counts the steps issued.
module step_ctrl
  import step_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CNT = 500000,
  parameter int unsigned CW      = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clk_10,
  input  logic          btn_step,
  input  logic          sw_auto,
  input  logic          start,
  input  logic          done,
  output logic          step_en,
  output logic          busy,
  output logic [1:0]    state,
  output logic [CW-1:0] step_count
);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  state_t st_r;
  logic   c1_p0;
  logic   c2_p1;
  logic   tick;
  logic   btn_pulse;

  btn_debounce #(
    .DEB_CNT (DEB_CNT)
  ) u_deb (
    .clk    (clk),
    .reset  (reset),
    .btn_in (btn_step),
    .pulse  (btn_pulse)
  );

  assign tick  = c1_p0 & ~c2_p1;
  assign state = st_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      c1_p0      <= 1'b0;
      c2_p1      <= 1'b0;
      st_r       <= ST_IDLE;
      busy       <= 1'b0;
      step_en    <= 1'b0;
      step_count <= '0;
    end else begin
      c1_p0   <= clk_10;
      c2_p1   <= c1_p0;
      step_en <= 1'b0;
      if (step_en) step_count <= sat_inc(step_count);

      // Stage boundary: next state and step decision, registered with busy
      case (st_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            st_r       <= sw_auto ? ST_AUTO : ST_STEP;
            busy       <= 1'b1;
            step_count <= '0;
          end
        end
        ST_AUTO: begin
          if (done) begin
            st_r <= ST_DONE;
            busy <= 1'b0;
          end else if (!sw_auto) begin
            st_r <= ST_STEP;
          end else begin
            step_en <= tick;
          end
        end
        ST_STEP: begin
          if (done) begin
            st_r <= ST_DONE;
            busy <= 1'b0;
          end else if (sw_auto) begin
            st_r <= ST_AUTO;
          end else begin
            step_en <= btn_pulse;
          end
        end
        default: begin
          st_r <= ST_IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule : step_ctrl

// File: tb/tb_step_ctrl.sv
// Directed bench for step_ctrl with a short debounce and a 3-bit step counter.
module tb_step_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clk_10 = 1'b0;
  logic       btn_step = 1'b0;
  logic       sw_auto = 1'b0;
  logic       start = 1'b0;
  logic       done = 1'b0;
  logic       step_en;
  logic       busy;
  logic [1:0] state;
  logic [2:0] step_count;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;

  step_ctrl #(
    .DEB_CNT (4),
    .CW      (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_10     (clk_10),
    .btn_step   (btn_step),
    .sw_auto    (sw_auto),
    .start      (start),
    .done       (done),
    .step_en    (step_en),
    .busy       (busy),
    .state      (state),
    .step_count (step_count)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clk_10 period: high for 5 clk, low for 5 clk
  task automatic clk10_period(input bit exp_pulse);
    for (int i = 0; i < 10; i++) begin
      clk_10 = (i < 5);
      cyc();
      chk("step_en_phase", step_en, (exp_pulse && i == 1));
      if (step_en) pulses++;
    end
  endtask

  initial begin
    // 1: reset with random inputs
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      clk_10   = 1'($urandom);
      btn_step = 1'($urandom);
      sw_auto  = 1'($urandom);
      start    = 1'($urandom);
      done     = 1'($urandom);
      cyc();
    end
    chk("rst_step_en", step_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", state, 0);
    chk("rst_count", step_count, 0);
    reset = 1'b0; clk_10 = 1'b0; btn_step = 1'b0; sw_auto = 1'b0; start = 1'b0; done = 1'b0;
    cyc();
    chk("idle_state", state, 0);

    // 2: auto-run
    sw_auto = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    chk("auto_state", state, 1);
    chk("auto_busy", busy, 1);
    chk("auto_count0", step_count, 0);
    clk10_period(1); chk("auto_count1", step_count, 1);
    clk10_period(1); chk("auto_count2", step_count, 2);
    clk10_period(1); chk("auto_count3", step_count, 3);

    // 3: manual single-step with bouncing button
    sw_auto = 1'b0;
    cyc();
    chk("switch_step_state", state, 2);
    chk("switch_step_en", step_en, 0);
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      btn_step = (i < 4) ? ~i[0] : 1'b1;
      cyc();
      if (step_en) pulses++;
    end
    chk("press_pulses", pulses, 1);
    chk("press_count", step_count, 4);
    btn_step = 1'b0;
    for (int i = 0; i < 14; i++) begin
      cyc();
      if (step_en) pulses++;
    end
    chk("release_pulses", pulses, 1);
    chk("release_count", step_count, 4);
    chk("step_busy", busy, 1);

    // 4: done coincident with tick
    sw_auto = 1'b1;
    cyc();
    chk("switch_auto_state", state, 1);
    chk("switch_auto_en", step_en, 0);
    clk10_period(1);
    chk("pre_done_count", step_count, 5);
    clk_10 = 1'b1;
    cyc();
    done = 1'b1;
    cyc();
    chk("done_step_en", step_en, 0);
    chk("done_state", state, 3);
    chk("done_busy", busy, 0);
    chk("done_count", step_count, 5);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      clk_10 = (i < 3);
      cyc();
      if (step_en) pulses++;
    end
    chk("done_hold_state", state, 3);
    chk("done_hold_pulses", pulses, 0);
    done = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    chk("restart_state", state, 1);
    chk("restart_busy", busy, 1);
    chk("restart_count", step_count, 0);

    // 5: reset in AUTO at count 5 with a pulse in flight
    for (int n = 0; n < 5; n++) clk10_period(1);
    chk("pre_reset_count", step_count, 5);
    clk_10 = 1'b1;
    cyc();
    cyc();
    chk("inflight_step_en", step_en, 1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("midrst_step_en", step_en, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_state", state, 0);
    chk("midrst_count", step_count, 0);
    for (int i = 0; i < 4; i++) begin
      clk_10 = (i < 3);
      cyc();
      chk("post_rst_en", step_en, 0);
    end
    clk10_period(0);
    clk10_period(0);
    chk("post_rst_state", state, 0);
    chk("post_rst_count", step_count, 0);
    done = 1'b1;
    cyc();
    done = 1'b0;
    chk("idle_ignores_done", state, 0);

    // 6: saturation over 9 steps
    sw_auto = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    chk("sat_start_state", state, 1);
    pulses = 0;
    for (int n = 0; n < 9; n++) begin
      clk10_period(1);
      chk("sat_count", step_count, (n + 1 < 7) ? n + 1 : 7);
    end
    chk("sat_pulses", pulses, 9);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("auto_ignores_start_state", state, 1);
    chk("auto_ignores_start_count", step_count, 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_step_ctrl
